// File: rtl/dram_bank_responder.sv
// dram_bank_responder
//   Cycle-accurate DRAM device model sitting on the responder side of a
//   controller command bus. Each bank tracks one open row and its own
//   activate/precharge timer; column accesses hit an internal array and
//   read data returns CAS_LAT cycles later through a shift pipeline.
//   Illegal command sequences are dropped and flagged one cycle later.
//
//   Bank FSM
//   state          | meaning
//   ---------------+---------------------------------------------------
//   B_IDLE         | no row open, ACT accepted, PRE is a no-op
//   B_ACTIVATING   | ACT seen, waiting out T_RCD, no access allowed
//   B_ACTIVE       | row open, RD/WR/PRE accepted
//   B_PRECHARGING  | PRE seen, waiting out T_RP, no access allowed
//
// Ports
//   clk             clock, all logic on rising edge
//   rst_b           synchronous active-low reset
//   cmd             00 NOP, 01 ACT, 10 RW, 11 PRE
//   cs              target bank
//   row_addr        row for ACT
//   col_addr        column for RW
//   rw              RW direction: 1 write, 0 read
//   dram_data_in    write data, taken with the WR command
//   dram_data_out   read data (0 when no read matures)
//   dram_data_valid read data valid
//   cmd_err         previous cycle's command was illegal
//   bank_open       per-bank ACTIVE flags
module dram_bank_responder #(
    parameter int DATA_WIDTH   = 1,
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2,
    parameter int CAS_LAT      = 2
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic [1:0]                      cmd,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] cs,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  row_addr,
    input  logic [$clog2(NUM_OF_COLS)-1:0]  col_addr,
    input  logic                            rw,
    input  logic [DATA_WIDTH-1:0]           dram_data_in,
    output logic [DATA_WIDTH-1:0]           dram_data_out,
    output logic                            dram_data_valid,
    output logic                            cmd_err,
    output logic [NUM_OF_BANKS-1:0]         bank_open
);

    localparam int BANK_W = $clog2(NUM_OF_BANKS);
    localparam int ROW_W  = $clog2(NUM_OF_ROWS);
    localparam int COL_W  = $clog2(NUM_OF_COLS);
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int DEPTH  = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
    localparam int T_MAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W  = $clog2(T_MAX + 1);

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_ACT = 2'b01;
    localparam logic [1:0] CMD_RW  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {
        B_IDLE,
        B_ACTIVATING,
        B_ACTIVE,
        B_PRECHARGING
    } bank_state_t;

    bank_state_t            state_q [NUM_OF_BANKS];
    bank_state_t            state_d [NUM_OF_BANKS];
    logic [CNT_W-1:0]       cnt_q   [NUM_OF_BANKS];
    logic [CNT_W-1:0]       cnt_d   [NUM_OF_BANKS];
    logic [ROW_W-1:0]       row_q   [NUM_OF_BANKS];
    logic [ROW_W-1:0]       row_d   [NUM_OF_BANKS];

    logic [DATA_WIDTH-1:0]  mem      [DEPTH];
    logic [DATA_WIDTH-1:0]  pipe_data[CAS_LAT];
    logic [CAS_LAT-1:0]     pipe_vld;

    bank_state_t            cur_state;
    logic                   illegal;
    logic                   rd_fire;
    logic                   wr_fire;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   cmd_err_q;

    // Command decode against the addressed bank's current state
    always_comb begin
        cur_state = state_q[cs];
        illegal   = 1'b0;
        case (cmd)
            CMD_ACT: illegal = (cur_state != B_IDLE);
            CMD_RW:  illegal = (cur_state != B_ACTIVE);
            CMD_PRE: illegal = (cur_state == B_ACTIVATING) || (cur_state == B_PRECHARGING);
            default: illegal = 1'b0;
        endcase
        rd_fire  = (cmd == CMD_RW) && !rw && (cur_state == B_ACTIVE);
        wr_fire  = (cmd == CMD_RW) &&  rw && (cur_state == B_ACTIVE);
        mem_addr = {cs, row_q[cs], col_addr};
        rd_data  = mem[mem_addr];
    end

    // Per-bank next state: timers run on every bank, the addressed bank
    // additionally takes a legal ACT/PRE. A legal ACT/PRE only hits banks
    // that are not counting, so the two updates never collide.
    always_comb begin
        for (int b = 0; b < NUM_OF_BANKS; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            row_d[b]   = row_q[b];
            case (state_q[b])
                B_ACTIVATING: begin
                    if (cnt_q[b] == CNT_W'(1)) state_d[b] = B_ACTIVE;
                    else                      cnt_d[b]   = cnt_q[b] - CNT_W'(1);
                end
                B_PRECHARGING: begin
                    if (cnt_q[b] == CNT_W'(1)) state_d[b] = B_IDLE;
                    else                      cnt_d[b]   = cnt_q[b] - CNT_W'(1);
                end
                default: ;
            endcase
            if ((cs == BANK_W'(b)) && !illegal) begin
                if (cmd == CMD_ACT) begin
                    row_d[b] = row_addr;
                    if (T_RCD == 1) begin
                        state_d[b] = B_ACTIVE;
                    end else begin
                        state_d[b] = B_ACTIVATING;
                        cnt_d[b]   = CNT_W'(T_RCD - 1);
                    end
                end else if ((cmd == CMD_PRE) && (state_q[b] == B_ACTIVE)) begin
                    if (T_RP == 1) begin
                        state_d[b] = B_IDLE;
                    end else begin
                        state_d[b] = B_PRECHARGING;
                        cnt_d[b]   = CNT_W'(T_RP - 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int b = 0; b < NUM_OF_BANKS; b++) begin
                state_q[b] <= B_IDLE;
                cnt_q[b]   <= '0;
                row_q[b]   <= '0;
            end
            cmd_err_q <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_OF_BANKS; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
                row_q[b]   <= row_d[b];
            end
            cmd_err_q <= illegal;
        end
    end

    // Read pipeline: slot k holds a read issued k+1 cycles ago; empty
    // slots carry zero data so the output is 0 whenever valid is low.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            pipe_vld <= '0;
            for (int k = 0; k < CAS_LAT; k++) pipe_data[k] <= '0;
        end else begin
            for (int k = CAS_LAT - 1; k > 0; k--) begin
                pipe_vld[k]  <= pipe_vld[k-1];
                pipe_data[k] <= pipe_data[k-1];
            end
            pipe_vld[0]  <= rd_fire;
            pipe_data[0] <= rd_fire ? rd_data : '0;
        end
    end

    // Array contents survive reset
    always_ff @(posedge clk) begin
        if (rst_b && wr_fire) mem[mem_addr] <= dram_data_in;
    end

    always_comb begin
        bank_open = '0;
        for (int b = 0; b < NUM_OF_BANKS; b++) bank_open[b] = (state_q[b] == B_ACTIVE);
    end

    assign dram_data_out   = pipe_data[CAS_LAT-1];
    assign dram_data_valid = pipe_vld[CAS_LAT-1];
    assign cmd_err         = cmd_err_q;

endmodule

// File: tb/tb_dram_bank_responder.sv
// tb_dram_bank_responder
//   Directed bench for dram_bank_responder. A timestamp-based bank model
//   (each bank remembers when it becomes ready rather than stepping a
//   counter) plus a read queue keyed on due cycle predicts every output
//   each cycle; literal expectations in the stimulus pin the model.
module tb_dram_bank_responder;

    localparam int DW    = 1;
    localparam int NB    = 8;
    localparam int NR    = 128;
    localparam int NC    = 8;
    localparam int T_RCD = 2;
    localparam int T_RP  = 2;
    localparam int CL    = 2;
    localparam int BW    = $clog2(NB);
    localparam int RWD   = $clog2(NR);
    localparam int CW    = $clog2(NC);

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] ACT = 2'b01;
    localparam logic [1:0] RWC = 2'b10;
    localparam logic [1:0] PRE = 2'b11;

    logic           clk = 1'b0;
    logic           rst_b;
    logic [1:0]     cmd;
    logic [BW-1:0]  cs;
    logic [RWD-1:0] row_addr;
    logic [CW-1:0]  col_addr;
    logic           rw;
    logic [DW-1:0]  dram_data_in;
    logic [DW-1:0]  dram_data_out;
    logic           dram_data_valid;
    logic           cmd_err;
    logic [NB-1:0]  bank_open;

    dram_bank_responder #(
        .DATA_WIDTH(DW), .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
        .T_RCD(T_RCD), .T_RP(T_RP), .CAS_LAT(CL)
    ) dut (
        .clk(clk), .rst_b(rst_b), .cmd(cmd), .cs(cs), .row_addr(row_addr),
        .col_addr(col_addr), .rw(rw), .dram_data_in(dram_data_in),
        .dram_data_out(dram_data_out), .dram_data_valid(dram_data_valid),
        .cmd_err(cmd_err), .bank_open(bank_open)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    bit checking = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int            due;
        bit            known;
        logic [DW-1:0] data;
    } rd_t;

    int            cyc = 0;
    bit            m_opened [NB];
    int            m_ready  [NB];
    int            m_row    [NB];
    logic [DW-1:0] m_mem    [int];
    rd_t           pend     [$];
    bit            m_err = 0;

    // 0 idle, 1 activating, 2 active, 3 precharging
    function automatic int bank_st(int b, int c);
        if (m_opened[b]) return (c >= m_ready[b]) ? 2 : 1;
        return (c >= m_ready[b]) ? 0 : 3;
    endfunction

    always @(posedge clk) begin
        if (!rst_b) begin
            for (int b = 0; b < NB; b++) begin
                m_opened[b] = 0;
                m_ready[b]  = 0;
                m_row[b]    = 0;
            end
            pend.delete();
            m_err = 0;
        end else begin
            int  b;
            int  s;
            int  a;
            bit  ill;
            rd_t r;
            b   = int'(cs);
            s   = bank_st(b, cyc);
            ill = 0;
            case (cmd)
                ACT: if (s != 0) ill = 1;
                     else begin
                         m_opened[b] = 1;
                         m_ready[b]  = cyc + T_RCD;
                         m_row[b]    = int'(row_addr);
                     end
                RWC: if (s != 2) ill = 1;
                     else begin
                         a = (b * NR + m_row[b]) * NC + int'(col_addr);
                         if (rw) m_mem[a] = dram_data_in;
                         else begin
                             r.due   = cyc + CL;
                             r.known = m_mem.exists(a);
                             r.data  = r.known ? m_mem[a] : '0;
                             pend.push_back(r);
                         end
                     end
                PRE: if (s == 1 || s == 3) ill = 1;
                     else if (s == 2) begin
                         m_opened[b] = 0;
                         m_ready[b]  = cyc + T_RP;
                     end
                default: ;
            endcase
            m_err = ill;
        end
        cyc++;
    end

    // Compare process: all outputs every cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (checking) begin
            logic [NB-1:0] e_open;
            bit            e_vld;
            e_vld = (pend.size() > 0) && (pend[0].due == cyc);
            check("m_valid", dram_data_valid, e_vld);
            if (e_vld) begin
                if (pend[0].known) check("m_rdata", dram_data_out, pend[0].data);
                void'(pend.pop_front());
            end else begin
                check("m_idle_data", dram_data_out, '0);
            end
            check("m_cmd_err", cmd_err, m_err);
            for (int b = 0; b < NB; b++) e_open[b] = (bank_st(b, cyc) == 2);
            check("m_bank_open", bank_open, e_open);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] c, input int b, input int r, input int col,
                         input logic w, input logic [DW-1:0] d);
        @(negedge clk);
        cmd          = c;
        cs           = BW'(b);
        row_addr     = RWD'(r);
        col_addr     = CW'(col);
        rw           = w;
        dram_data_in = d;
    endtask

    task automatic nop();
        issue(NOP, 0, 0, 0, 1'b0, '0);
    endtask

    logic [DW-1:0] alt_exp [4];

    initial begin
        rst_b = 1'b0; cmd = NOP; cs = '0; row_addr = '0; col_addr = '0;
        rw = 1'b0; dram_data_in = '0;
        repeat (2) @(negedge clk);
        checking = 1;
        check("rst_bank_open", bank_open, 8'h00);
        check("rst_valid", dram_data_valid, 1'b0);
        check("rst_err", cmd_err, 1'b0);
        check("rst_data", dram_data_out, 1'b0);
        rst_b = 1'b1;

        // basic ACT / WR / RD on bank 3
        issue(ACT, 3, 'h45, 0, 1'b0, 1'b0);
        nop();
        issue(RWC, 3, 0, 5, 1'b1, 1'b1);
        check("t1_bank_open", bank_open, 8'h08);
        issue(RWC, 3, 0, 5, 1'b0, 1'b0);
        nop();
        check("t1_no_err", cmd_err, 1'b0);
        nop();
        check("t1_valid", dram_data_valid, 1'b1);
        check("t1_data", dram_data_out, 1'b1);

        // RD before T_RCD
        issue(ACT, 0, 0, 0, 1'b0, 1'b0);
        issue(RWC, 0, 0, 1, 1'b0, 1'b0);
        issue(RWC, 0, 0, 1, 1'b0, 1'b0);
        check("t2_err", cmd_err, 1'b1);
        nop();
        check("t2_no_valid", dram_data_valid, 1'b0);
        nop();
        check("t2_valid", dram_data_valid, 1'b1);

        // two banks, alternating back-to-back reads
        issue(ACT, 1, 7, 0, 1'b0, 1'b0);
        issue(ACT, 6, 100, 0, 1'b0, 1'b0);
        nop();
        issue(RWC, 1, 0, 0, 1'b1, 1'b1);
        issue(RWC, 6, 0, 0, 1'b1, 1'b0);
        alt_exp[0] = 1'b1; alt_exp[1] = 1'b0; alt_exp[2] = 1'b1; alt_exp[3] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) issue(RWC, (i % 2 == 1) ? 6 : 1, 0, 0, 1'b0, 1'b0);
            else       nop();
            if (i >= 2) begin
                check("t3_valid", dram_data_valid, 1'b1);
                check("t3_data", dram_data_out, alt_exp[i-2]);
            end
        end

        // PRE then early ACT, then legal ACT; PRE to idle bank
        issue(ACT, 2, 3, 0, 1'b0, 1'b0);
        nop();
        nop();
        check("t4_open_before", bank_open[2], 1'b1);
        issue(PRE, 2, 0, 0, 1'b0, 1'b0);
        issue(ACT, 2, 9, 0, 1'b0, 1'b0);
        check("t4_closed", bank_open[2], 1'b0);
        issue(ACT, 2, 5, 0, 1'b0, 1'b0);
        check("t4_err", cmd_err, 1'b1);
        nop();
        check("t4_activating", bank_open[2], 1'b0);
        check("t4_err_clear", cmd_err, 1'b0);
        nop();
        check("t4_reopen", bank_open[2], 1'b1);
        issue(PRE, 5, 0, 0, 1'b0, 1'b0);
        nop();
        check("t4_pre_idle_ok", cmd_err, 1'b0);

        // consecutive illegal ACTs on an active bank
        issue(ACT, 2, 1, 0, 1'b0, 1'b0);
        issue(ACT, 2, 1, 0, 1'b0, 1'b0);
        check("t4_err_seq1", cmd_err, 1'b1);
        nop();
        check("t4_err_seq2", cmd_err, 1'b1);
        nop();
        check("t4_err_seq3", cmd_err, 1'b0);

        // reset in the middle of a read
        issue(RWC, 2, 0, 4, 1'b1, 1'b1);
        issue(RWC, 2, 0, 4, 1'b0, 1'b0);
        nop();
        rst_b = 1'b0;
        nop();
        check("t5_no_valid", dram_data_valid, 1'b0);
        check("t5_closed", bank_open, 8'h00);
        nop();
        rst_b = 1'b1;
        nop();
        check("t5_no_valid_late", dram_data_valid, 1'b0);
        issue(ACT, 2, 5, 0, 1'b0, 1'b0);
        nop();
        issue(RWC, 2, 0, 4, 1'b0, 1'b0);
        nop();
        nop();
        check("t5_kept_valid", dram_data_valid, 1'b1);
        check("t5_kept_data", dram_data_out, 1'b1);

        // row isolation on bank 4
        issue(ACT, 4, 11, 0, 1'b0, 1'b0);
        nop();
        issue(RWC, 4, 0, 3, 1'b1, 1'b0);
        issue(PRE, 4, 0, 0, 1'b0, 1'b0);
        nop();
        issue(ACT, 4, 10, 0, 1'b0, 1'b0);
        nop();
        issue(RWC, 4, 0, 3, 1'b1, 1'b1);
        issue(PRE, 4, 0, 0, 1'b0, 1'b0);
        nop();
        issue(ACT, 4, 11, 0, 1'b0, 1'b0);
        nop();
        issue(RWC, 4, 0, 3, 1'b0, 1'b0);
        nop();
        nop();
        check("t6_valid", dram_data_valid, 1'b1);
        check("t6_data", dram_data_out, 1'b0);

        repeat (3) nop();
        checking = 0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dram_bank_responder.md
Name: dram_bank_responder

Overview:
- Cycle-accurate DRAM device model: the responder side of the DRAM controller's command bus.
- Decodes cmd/bank/row/col and keeps one open row and a timing FSM per bank.
- Stores data in an internal array, returns read data after CAS latency, and flags illegal command sequences.
- Used as the DUT-facing memory in controller system benches and as a standalone block.

Parameters:
DATA_WIDTH, 1, data bits per column location
NUM_OF_BANKS, 8, number of banks (power of 2)
NUM_OF_ROWS, 128, rows per bank (power of 2)
NUM_OF_COLS, 8, columns per row (power of 2)
T_RCD, 2, cycles from ACT to first legal RD/WR on that bank (>=1)
T_RP, 2, cycles from PRE until bank is IDLE (>=1)
CAS_LAT, 2, cycles from RD to read data valid (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
rst_b  input  1  synchronous active-low reset
cmd  input  2  00 NOP, 01 ACT, 10 RW (column access), 11 PRE
cs  input  $clog2(NUM_OF_BANKS)  target bank of cmd
row_addr  input  $clog2(NUM_OF_ROWS)  row to open; used by ACT only
col_addr  input  $clog2(NUM_OF_COLS)  column; used by RW only
rw  input  1  for cmd=RW: 1 write, 0 read
dram_data_in  input  DATA_WIDTH  write data, sampled with the WR command
dram_data_out  output  DATA_WIDTH  read data
dram_data_valid  output  1  dram_data_out valid this cycle
cmd_err  output  1  one-cycle pulse: previous cycle's command was illegal
bank_open  output  NUM_OF_BANKS  bit b=1 when bank b is ACTIVE

Behaviour:
- Reset (rst_b=0 at a clock edge):
  - All banks go to IDLE; open_row and counters clear; read pipeline is flushed.
  - dram_data_out=0, dram_data_valid=0, cmd_err=0, bank_open=0.
  - Array contents are not reset.
  - Reset mid-read: any pending read data is discarded and never asserts valid.
- Per-bank FSM states: IDLE, ACTIVATING, ACTIVE, PRECHARGING.
- Command timing. A command presented in cycle n is sampled at the end of cycle n. Only one command per cycle; banks not addressed keep counting independently.
- ACT to an IDLE bank:
  - Latches open_row=row_addr.
  - If T_RCD=1, bank goes to ACTIVE. Otherwise it goes to ACTIVATING with the counter loaded to T_RCD-1 and decremented each cycle; it moves to ACTIVE when the counter reaches 1.
  - Net result: the bank is ACTIVE from cycle n+T_RCD.
- ACT to a non-IDLE bank: illegal.
- RW to an ACTIVE bank:
  - Address is {cs, open_row[cs], col_addr}; row_addr is ignored.
  - Write (rw=1): array is written with dram_data_in at the end of cycle n. A RD to the same address in cycle n+1 returns the new data.
  - Read (rw=0): array is read in cycle n. dram_data_out and dram_data_valid=1 appear in cycle n+CAS_LAT for exactly one cycle.
  - Reads are pipelined through a CAS_LAT-deep shift register, so back-to-back RDs give back-to-back valid data.
  - When no read matures in a cycle, valid=0 and dram_data_out=0.
- RW to a bank not ACTIVE: illegal.
- PRE:
  - On an ACTIVE bank: T_RP=1 goes to IDLE; otherwise the bank goes to PRECHARGING and is IDLE from cycle n+T_RP. bank_open bit clears from cycle n+1.
  - On an IDLE bank: legal no-op.
  - On an ACTIVATING or PRECHARGING bank: illegal.
- NOP: always legal, no effect.
- Illegal command:
  - No state, array or pipeline change.
  - cmd_err=1 in cycle n+1 only; consecutive illegal commands give consecutive pulses.
- Out-of-range handling: none. All address widths exactly cover their ranges.

Test Plan:
- Reset, then ACT bank3 row 0x45 in cycle 0; WR col5 data=1 in cycle 2; RD col5 in cycle 3 -> dram_data_valid=1, dram_data_out=1 in cycle 5; cmd_err stays 0; bank_open=8'b0000_1000 from cycle 2.
- ACT bank0 cycle 0, RD bank0 cycle 1 (before T_RCD) -> cmd_err=1 in cycle 2, no valid in cycle 3. RD in cycle 2 -> valid in cycle 4.
- Open bank1 row 7 and bank6 row 100; WR distinct values to col0 of each; 4 back-to-back RDs alternating banks -> 4 consecutive valid cycles with matching data, no cross-bank aliasing.
- PRE bank2 while ACTIVE in cycle n, ACT bank2 in cycle n+1 -> cmd_err in n+2. ACT in cycle n+2 accepted, bank_open[2]=1 at n+2+T_RCD. PRE to an IDLE bank gives no cmd_err.
- Issue RD in cycle n; assert rst_b=0 in cycle n+1 -> dram_data_valid stays 0 through n+4 and bank_open=0. Previously written data is still readable after re-ACT.
- Row isolation: WR bank4 row10 col3=1; PRE; ACT row11; RD col3 -> returns the row-11 value (0 if never written), not 1.
